// File: rtl/anim_pkg.sv
// Shared types and constants for the sprite animation path: pacer states,
// the movement keycodes, and the motion codes consumed by the sprite FSM.
package anim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        HELD = 2'd2
    } pacer_state_t;

    localparam logic [7:0] KEY_NONE  = 8'd0;
    localparam logic [7:0] KEY_RIGHT = 8'd79;
    localparam logic [7:0] KEY_LEFT  = 8'd80;

    localparam logic [3:0] MOTION_STAND      = 4'd0;
    localparam logic [3:0] MOTION_WALK_RIGHT = 4'd1;
    localparam logic [3:0] MOTION_WALK_LEFT  = 4'd2;
    localparam logic [3:0] MOTION_OTHER      = 4'd15;

    function automatic logic [3:0] key_to_motion(input logic [7:0] key);
        case (key)
            KEY_NONE:  return MOTION_STAND;
            KEY_RIGHT: return MOTION_WALK_RIGHT;
            KEY_LEFT:  return MOTION_WALK_LEFT;
            default:   return MOTION_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/frame_sync_edge.sv
// Brings the asynchronous active-low vsync into the Clk domain and produces a
// registered one-cycle frame_tick per falling edge.
module frame_sync_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_sync_n,
    output logic frame_tick
);

    logic sync_meta;
    logic sync_stable;
    logic sync_d;
    logic sync_dd;
    logic fall;

    // Edge detect runs one stage behind the synchronizer so that the tick
    // leaves on the fourth edge after vsync is first sampled low.
    assign fall = sync_dd & ~sync_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_meta   <= 1'b1;
            sync_stable <= 1'b1;
            sync_d      <= 1'b1;
            sync_dd     <= 1'b1;
            frame_tick  <= 1'b0;
        end else begin
            sync_meta   <= frame_sync_n;
            sync_stable <= sync_meta;
            sync_d      <= sync_stable;
            sync_dd     <= sync_d;
            frame_tick  <= fall;
        end
    end

endmodule

// File: rtl/anim_pacer.sv
// Per-frame key debouncer and animation-step pacer feeding the sprite FSM.
// Optional macro ANIM_PACER_FIRST_STEP_EN: emit anim_step on key acceptance.
module anim_pacer
    import anim_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 6,
    parameter int STABLE_FRAMES   = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_sync_n,
    input  logic [7:0] Keycode,
    output logic       frame_tick,
    output logic [7:0] key_out,
    output logic       key_valid,
    output logic       anim_step
);

`ifdef ANIM_PACER_FIRST_STEP_EN
    localparam logic FIRST_STEP = 1'b1;
`else
    localparam logic FIRST_STEP = 1'b0;
`endif

    localparam logic [7:0] STEP_LOAD = 8'(FRAMES_PER_STEP);
    localparam logic [3:0] STABLE_N  = 4'(STABLE_FRAMES);

    pacer_state_t state;
    logic [7:0]   cand;
    logic [3:0]   cnt;
    logic [3:0]   mis;
    logic [7:0]   step_cnt;

    frame_sync_edge u_frame_sync_edge (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_sync_n (frame_sync_n),
        .frame_tick   (frame_tick)
    );

    // Everything except the anim_step clear advances only on frame_tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cand      <= 8'd0;
            cnt       <= 4'd0;
            mis       <= 4'd0;
            step_cnt  <= 8'd0;
            key_out   <= 8'd0;
            key_valid <= 1'b0;
            anim_step <= 1'b0;
        end else begin
            anim_step <= 1'b0;
            if (frame_tick) begin
                case (state)
                    IDLE: begin
                        if (Keycode != 8'd0) begin
                            cand <= Keycode;
                            cnt  <= 4'd1;
                            if (STABLE_N == 4'd1) begin
                                state     <= HELD;
                                key_out   <= Keycode;
                                key_valid <= 1'b1;
                                step_cnt  <= STEP_LOAD;
                                mis       <= 4'd0;
                                anim_step <= FIRST_STEP;
                            end else begin
                                state <= QUAL;
                            end
                        end
                    end
                    QUAL: begin
                        if (Keycode == cand) begin
                            cnt <= cnt + 4'd1;
                            if (cnt + 4'd1 == STABLE_N) begin
                                state     <= HELD;
                                key_out   <= cand;
                                key_valid <= 1'b1;
                                step_cnt  <= STEP_LOAD;
                                mis       <= 4'd0;
                                anim_step <= FIRST_STEP;
                            end
                        end else if (Keycode == 8'd0) begin
                            state <= IDLE;
                            cnt   <= 4'd0;
                        end else begin
                            cand <= Keycode;
                            cnt  <= 4'd1;
                        end
                    end
                    HELD: begin
                        if (Keycode == key_out) begin
                            mis <= 4'd0;
                            if (step_cnt == 8'd1) begin
                                step_cnt  <= STEP_LOAD;
                                anim_step <= 1'b1;
                            end else begin
                                step_cnt <= step_cnt - 8'd1;
                            end
                        end else if (mis + 4'd1 == STABLE_N) begin
                            // Key lost: drop it, then treat this sample as a fresh first sample.
                            key_out   <= 8'd0;
                            key_valid <= 1'b0;
                            mis       <= 4'd0;
                            step_cnt  <= 8'd0;
                            if (Keycode == 8'd0) begin
                                state <= IDLE;
                                cnt   <= 4'd0;
                            end else begin
                                cand <= Keycode;
                                cnt  <= 4'd1;
                                if (STABLE_N == 4'd1) begin
                                    state     <= HELD;
                                    key_out   <= Keycode;
                                    key_valid <= 1'b1;
                                    step_cnt  <= STEP_LOAD;
                                    anim_step <= FIRST_STEP;
                                end else begin
                                    state <= QUAL;
                                end
                            end
                        end else begin
                            mis <= mis + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
